// File: rtl/sprite_compositor_if.sv
// Sprite ROM bus: per-sprite read addresses out of the compositor and
// palette-resolved colours back, one cycle later.
interface sprite_compositor_if #(
  parameter int NUM_SPRITES = 4,
  parameter int COLOR_BITS  = 12,
  parameter int ADDR_BITS   = 12
);
  logic [ADDR_BITS*NUM_SPRITES-1:0]  spriteAddr;
  logic [COLOR_BITS*NUM_SPRITES-1:0] spriteColor;

  modport master (output spriteAddr, input spriteColor);
  modport slave  (input spriteAddr, output spriteColor);
endinterface

// File: rtl/sprite_compositor.sv
// Three-stage sprite compositor: hit test + ROM addressing, transparency and
// fixed-priority resolve, registered colour out, plus per-frame collision report.
module sprite_compositor #(
  parameter int                    NUM_SPRITES = 4,
  parameter int                    SPRITE_SIZE = 64,
  parameter int                    COLOR_BITS  = 12,
  parameter logic [COLOR_BITS-1:0] TRANSPARENT = 12'hF0F,
  parameter int                    ADDR_BITS   = $clog2(SPRITE_SIZE*SPRITE_SIZE)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          screenEnd,
  input  logic                          active,
  input  logic                          hSync,
  input  logic                          vSync,
  input  logic [9:0]                    x,
  input  logic [8:0]                    y,
  input  logic [32*NUM_SPRITES-1:0]     spritePos,
  sprite_compositor_if.master           rom,
  input  logic [COLOR_BITS-1:0]         bgColor,
  output logic [COLOR_BITS-1:0]         colorOut,
  output logic                          activeOut,
  output logic                          hSyncOut,
  output logic                          vSyncOut,
  output logic [NUM_SPRITES-1:0]        collisionMask,
  output logic [15:0]                   frameCount
);

  localparam int         SB   = $clog2(SPRITE_SIZE);
  localparam logic [10:0] SZ_X = 11'(SPRITE_SIZE);
  localparam logic [9:0]  SZ_Y = 10'(SPRITE_SIZE);

  logic [32*NUM_SPRITES-1:0]        shadow_q;
  logic [NUM_SPRITES-1:0]           inside_d, inside_p1_q, inside_p2_q;
  logic [ADDR_BITS*NUM_SPRITES-1:0] addr_d, addr_p1_q;
  logic                             act_p1_q, hs_p1_q, vs_p1_q;
  logic                             act_p2_q, hs_p2_q, vs_p2_q;
  logic [COLOR_BITS-1:0]            color_d, color_p3_q;
  logic                             act_p3_q, hs_p3_q, vs_p3_q;
  logic [NUM_SPRITES-1:0]           opaque, opaque_less1, contrib;
  logic [NUM_SPRITES-1:0]           coll_work_d, coll_work_q, coll_mask_d, coll_mask_q;
  logic [15:0]                      frame_cnt_d, frame_cnt_q;

  // Positions only change at the frame boundary so a frame never tears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) shadow_q <= '0;
    else if (screenEnd) shadow_q <= spritePos;
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_hit
    logic [9:0]  sx, dx;
    logic [8:0]  sy, dy;
    logic [10:0] x_end;
    logic [9:0]  y_end;
    logic        en;
    logic        unused_bits;

    assign sx    = shadow_q[32*g+22 +: 10];
    assign sy    = shadow_q[32*g+13 +: 9];
    assign en    = shadow_q[32*g];
    // One bit wider so a sprite near the right/bottom edge does not wrap to 0.
    assign x_end = {1'b0, sx} + SZ_X;
    assign y_end = {1'b0, sy} + SZ_Y;
    assign dx    = x - sx;
    assign dy    = y - sy;
    assign inside_d[g] = en && (x >= sx) && ({1'b0, x} < x_end)
                            && (y >= sy) && ({1'b0, y} < y_end);
    assign addr_d[ADDR_BITS*g +: ADDR_BITS] = {dy[SB-1:0], dx[SB-1:0]};
    assign unused_bits = ^{shadow_q[32*g+1 +: 12], dx[9:SB], dy[8:SB]};
  end

  // Stage 1: hit flags, ROM addresses, timing signals
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inside_p1_q <= '0;
      addr_p1_q   <= '0;
      act_p1_q    <= 1'b0;
      hs_p1_q     <= 1'b0;
      vs_p1_q     <= 1'b0;
    end else begin
      inside_p1_q <= inside_d;
      addr_p1_q   <= addr_d;
      act_p1_q    <= active;
      hs_p1_q     <= hSync;
      vs_p1_q     <= vSync;
    end
  end

  assign rom.spriteAddr = addr_p1_q;

  // Stage 2: align with the ROM's one-cycle read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inside_p2_q <= '0;
      act_p2_q    <= 1'b0;
      hs_p2_q     <= 1'b0;
      vs_p2_q     <= 1'b0;
    end else begin
      inside_p2_q <= inside_p1_q;
      act_p2_q    <= act_p1_q;
      hs_p2_q     <= hs_p1_q;
      vs_p2_q     <= vs_p1_q;
    end
  end

  // Walk from lowest to highest priority so sprite 0 is written last and wins.
  always_comb begin
    opaque  = '0;
    color_d = bgColor;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      opaque[i] = inside_p2_q[i] &&
                  (rom.spriteColor[COLOR_BITS*i +: COLOR_BITS] != TRANSPARENT);
      if (opaque[i]) color_d = rom.spriteColor[COLOR_BITS*i +: COLOR_BITS];
    end
    if (!act_p2_q) color_d = '0;
  end

  // Clearing the lowest set bit leaves something only when two or more are set.
  assign opaque_less1 = opaque - NUM_SPRITES'(1);
  assign contrib      = (act_p2_q && |(opaque & opaque_less1)) ? opaque : '0;

  always_comb begin
    coll_work_d = coll_work_q | contrib;
    coll_mask_d = coll_mask_q;
    frame_cnt_d = frame_cnt_q;
    if (screenEnd) begin
      coll_mask_d = coll_work_q | contrib;
      coll_work_d = '0;
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      coll_work_q <= '0;
      coll_mask_q <= '0;
      frame_cnt_q <= '0;
    end else begin
      coll_work_q <= coll_work_d;
      coll_mask_q <= coll_mask_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Stage 3: registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      color_p3_q <= '0;
      act_p3_q   <= 1'b0;
      hs_p3_q    <= 1'b0;
      vs_p3_q    <= 1'b0;
    end else begin
      color_p3_q <= color_d;
      act_p3_q   <= act_p2_q;
      hs_p3_q    <= hs_p2_q;
      vs_p3_q    <= vs_p2_q;
    end
  end

  assign colorOut      = color_p3_q;
  assign activeOut     = act_p3_q;
  assign hSyncOut      = hs_p3_q;
  assign vSyncOut      = vs_p3_q;
  assign collisionMask = coll_mask_q;
  assign frameCount    = frame_cnt_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor with a one-cycle-latency ROM model.
module tb_sprite_compositor;
  localparam int          NS = 4;
  localparam int          CB = 12;
  localparam int          AB = 12;
  localparam logic [11:0] BG = 12'h111;

  logic          clk = 1'b0;
  logic          reset, screenEnd, active, hSync, vSync;
  logic [9:0]    x;
  logic [8:0]    y;
  logic [127:0]  spritePos;
  logic [11:0]   bgColor, colorOut;
  logic          activeOut, hSyncOut, vSyncOut;
  logic [3:0]    collisionMask;
  logic [15:0]   frameCount;
  logic [11:0]   rom_col [NS];
  logic          corner_en;
  int            passed = 0;
  int            total  = 0;
  int            exp_fc = 0;

  sprite_compositor_if #(.NUM_SPRITES(NS), .COLOR_BITS(CB), .ADDR_BITS(AB)) rom_if ();

  sprite_compositor dut (
    .clk(clk), .reset(reset), .screenEnd(screenEnd),
    .active(active), .hSync(hSync), .vSync(vSync),
    .x(x), .y(y), .spritePos(spritePos), .rom(rom_if), .bgColor(bgColor),
    .colorOut(colorOut), .activeOut(activeOut), .hSyncOut(hSyncOut),
    .vSyncOut(vSyncOut), .collisionMask(collisionMask), .frameCount(frameCount)
  );

  always #5 clk = ~clk;

  // ROM model: sprite 0 returns a marker colour at address 0 when enabled.
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++) begin
      if (i == 0 && corner_en && rom_if.spriteAddr[11:0] == 12'd0)
        rom_if.spriteColor[12*i +: 12] <= 12'h123;
      else
        rom_if.spriteColor[12*i +: 12] <= rom_col[i];
    end
  end

  function automatic logic [31:0] mk(input int px, input int py, input logic en);
    return {px[9:0], py[8:0], 12'd0, en};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int px, input int py, output logic [47:0] a, output logic [11:0] c);
    x = px[9:0]; y = py[8:0]; active = 1'b1;
    step();
    a = rom_if.spriteAddr;
    active = 1'b0;
    step();
    step();
    c = colorOut;
  endtask

  task automatic frame_end();
    screenEnd = 1'b1; active = 1'b0;
    step();
    screenEnd = 1'b0;
    exp_fc++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (colorOut !== 12'h000) $display("FAIL rst_color got=%h exp=000", colorOut); else passed++;
    total++; if (rom_if.spriteAddr !== 48'h0) $display("FAIL rst_addr got=%h exp=0", rom_if.spriteAddr); else passed++;
    total++; if (activeOut !== 1'b0) $display("FAIL rst_active got=%b exp=0", activeOut); else passed++;
    total++; if (hSyncOut !== 1'b0) $display("FAIL rst_hsync got=%b exp=0", hSyncOut); else passed++;
    total++; if (vSyncOut !== 1'b0) $display("FAIL rst_vsync got=%b exp=0", vSyncOut); else passed++;
    total++; if (collisionMask !== 4'h0) $display("FAIL rst_coll got=%h exp=0", collisionMask); else passed++;
    total++; if (frameCount !== 16'h0) $display("FAIL rst_fc got=%h exp=0", frameCount); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    int          tx [8] = '{100, 163, 130,  99, 164, 100, 100, 163};
    int          ty [8] = '{ 50, 113,  80,  50,  50,  49, 114,  50};
    logic [11:0] tc [8] = '{12'h0F0, 12'h0F0, 12'h0F0, BG, BG, BG, BG, 12'h0F0};
    logic [11:0] ta [3] = '{12'd0, 12'd4095, 12'd1950};
    logic [47:0] a;
    logic [11:0] c;
    spritePos = {32'd0, 32'd0, 32'd0, mk(100, 50, 1'b1)};
    rom_col[0] = 12'h0F0;
    frame_end();
    for (int i = 0; i < 8; i++) begin
      pix(tx[i], ty[i], a, c);
      total++; if (c !== tc[i]) $display("FAIL single_color(%0d,%0d) got=%h exp=%h", tx[i], ty[i], c, tc[i]); else passed++;
      if (i < 3) begin
        total++; if (a[11:0] !== ta[i]) $display("FAIL single_addr(%0d,%0d) got=%0d exp=%0d", tx[i], ty[i], a[11:0], ta[i]); else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int          xx;
    logic [11:0] e;
    corner_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin x = 10'(97 + k); y = 9'd50; active = 1'b1; end
      else active = 1'b0;
      step();
      if (k >= 2) begin
        xx = 95 + k;
        e  = (xx < 100) ? BG : ((xx == 100) ? 12'h123 : 12'h0F0);
        total++; if (colorOut !== e) $display("FAIL b2b_color x=%0d got=%h exp=%h", xx, colorOut, e); else passed++;
        total++; if (activeOut !== 1'b1) $display("FAIL b2b_active x=%0d got=%b exp=1", xx, activeOut); else passed++;
      end
    end
    corner_en = 1'b0;
  endtask

  task automatic test_priority();
    logic [47:0] a;
    logic [11:0] c;
    spritePos = {32'd0, 32'd0, mk(232, 100, 1'b1), mk(200, 100, 1'b1)};
    rom_col[0] = 12'hF0F; rom_col[1] = 12'h00F;
    frame_end();
    pix(240, 110, a, c);
    total++; if (c !== 12'h00F) $display("FAIL prio_transp_overlap got=%h exp=00F", c); else passed++;
    pix(210, 110, a, c);
    total++; if (c !== BG) $display("FAIL prio_transp_alone got=%h exp=%h", c, BG); else passed++;
    pix(280, 110, a, c);
    total++; if (c !== 12'h00F) $display("FAIL prio_s1_alone got=%h exp=00F", c); else passed++;
    rom_col[0] = 12'hF00;
    pix(240, 110, a, c);
    total++; if (c !== 12'hF00) $display("FAIL prio_opaque_overlap got=%h exp=F00", c); else passed++;
    pix(210, 110, a, c);
    total++; if (c !== 12'hF00) $display("FAIL prio_s0_alone got=%h exp=F00", c); else passed++;
  endtask

  task automatic test_tear_free();
    logic [47:0] a;
    logic [11:0] c;
    spritePos = {32'd0, 32'd0, mk(232, 100, 1'b1), mk(400, 200, 1'b1)};
    pix(210, 110, a, c);
    total++; if (c !== 12'hF00) $display("FAIL tear_old_pos got=%h exp=F00", c); else passed++;
    pix(410, 210, a, c);
    total++; if (c !== BG) $display("FAIL tear_new_pos_early got=%h exp=%h", c, BG); else passed++;
    // Pixel presented in the screenEnd cycle still sees the old position.
    x = 10'd210; y = 9'd110; active = 1'b1; screenEnd = 1'b1;
    step();
    screenEnd = 1'b0; active = 1'b0; exp_fc++;
    step();
    step();
    total++; if (colorOut !== 12'hF00) $display("FAIL tear_boundary_pixel got=%h exp=F00", colorOut); else passed++;
    total++; if (collisionMask !== 4'b0011) $display("FAIL tear_coll got=%b exp=0011", collisionMask); else passed++;
    total++; if (frameCount !== exp_fc[15:0]) $display("FAIL tear_fc got=%0d exp=%0d", frameCount, exp_fc); else passed++;
    pix(410, 210, a, c);
    total++; if (c !== 12'hF00) $display("FAIL tear_new_pos got=%h exp=F00", c); else passed++;
    pix(210, 110, a, c);
    total++; if (c !== BG) $display("FAIL tear_old_gone got=%h exp=%h", c, BG); else passed++;
    pix(240, 110, a, c);
    total++; if (c !== 12'h00F) $display("FAIL tear_s1 got=%h exp=00F", c); else passed++;
  endtask

  task automatic test_collision();
    logic [47:0] a;
    logic [11:0] c;
    spritePos = {32'd0, mk(163, 113, 1'b1), mk(100, 50, 1'b1), 32'd0};
    rom_col[1] = 12'h0F0; rom_col[2] = 12'h00F;
    frame_end();
    total++; if (collisionMask !== 4'b0000) $display("FAIL coll_clean got=%b exp=0000", collisionMask); else passed++;
    pix(163, 113, a, c);
    total++; if (c !== 12'h0F0) $display("FAIL coll_pixel got=%h exp=0F0", c); else passed++;
    frame_end();
    total++; if (collisionMask !== 4'b0110) $display("FAIL coll_hit got=%b exp=0110", collisionMask); else passed++;
    total++; if (frameCount !== exp_fc[15:0]) $display("FAIL coll_fc got=%0d exp=%0d", frameCount, exp_fc); else passed++;
    pix(162, 113, a, c);
    total++; if (c !== 12'h0F0) $display("FAIL coll_near got=%h exp=0F0", c); else passed++;
    total++; if (collisionMask !== 4'b0110) $display("FAIL coll_hold got=%b exp=0110", collisionMask); else passed++;
    frame_end();
    total++; if (collisionMask !== 4'b0000) $display("FAIL coll_none got=%b exp=0000", collisionMask); else passed++;
    rom_col[1] = 12'hF0F;
    pix(163, 113, a, c);
    total++; if (c !== 12'h00F) $display("FAIL coll_transp_pixel got=%h exp=00F", c); else passed++;
    frame_end();
    total++; if (collisionMask !== 4'b0000) $display("FAIL coll_transp got=%b exp=0000", collisionMask); else passed++;
  endtask

  task automatic test_blanking_latency();
    logic [7:0]  hp = 8'b1011_0010;
    logic [7:0]  vp = 8'b0110_1001;
    logic [7:0]  ap = 8'b1100_1010;
    logic [47:0] a;
    logic [11:0] c, e;
    x = 10'd170; y = 9'd120; active = 1'b0;
    step(); step(); step();
    total++; if (colorOut !== 12'h000) $display("FAIL blank_color got=%h exp=000", colorOut); else passed++;
    pix(170, 120, a, c);
    total++; if (c !== 12'h00F) $display("FAIL blank_contrast got=%h exp=00F", c); else passed++;
    for (int k = 0; k < 10; k++) begin
      if (k < 8) begin hSync = hp[k]; vSync = vp[k]; active = ap[k]; end
      else begin hSync = 1'b0; vSync = 1'b0; active = 1'b0; end
      step();
      if (k >= 2) begin
        e = ap[k-2] ? 12'h00F : 12'h000;
        total++; if (hSyncOut !== hp[k-2]) $display("FAIL lat_hsync k=%0d got=%b exp=%b", k, hSyncOut, hp[k-2]); else passed++;
        total++; if (vSyncOut !== vp[k-2]) $display("FAIL lat_vsync k=%0d got=%b exp=%b", k, vSyncOut, vp[k-2]); else passed++;
        total++; if (activeOut !== ap[k-2]) $display("FAIL lat_active k=%0d got=%b exp=%b", k, activeOut, ap[k-2]); else passed++;
        total++; if (colorOut !== e) $display("FAIL lat_color k=%0d got=%h exp=%h", k, colorOut, e); else passed++;
      end
    end
  endtask

  task automatic test_boundaries();
    int          tx [10] = '{0, 63, 64,  0,   0,  39, 1000, 1023, 1023, 999};
    int          ty [10] = '{0, 63,  0, 64, 210, 210,  210,  263,  264, 210};
    logic [11:0] tc [10] = '{12'h0F0, 12'h0F0, BG, BG, BG, BG, 12'h0FF, 12'h0FF, BG, BG};
    logic [47:0] a;
    logic [11:0] c;
    spritePos = {mk(1000, 200, 1'b1), 32'd0, 32'd0, mk(0, 0, 1'b1)};
    rom_col[0] = 12'h0F0; rom_col[3] = 12'h0FF;
    frame_end();
    for (int i = 0; i < 10; i++) begin
      pix(tx[i], ty[i], a, c);
      total++; if (c !== tc[i]) $display("FAIL edge_color(%0d,%0d) got=%h exp=%h", tx[i], ty[i], c, tc[i]); else passed++;
      if (i == 0) begin total++; if (a[11:0] !== 12'd0) $display("FAIL edge_addr0 got=%0d exp=0", a[11:0]); else passed++; end
      if (i == 1) begin total++; if (a[11:0] !== 12'd4095) $display("FAIL edge_addr63 got=%0d exp=4095", a[11:0]); else passed++; end
      if (i == 7) begin total++; if (a[47:36] !== 12'd4055) $display("FAIL edge_addr_s3 got=%0d exp=4055", a[47:36]); else passed++; end
    end
  endtask

  task automatic test_async_reset();
    logic [47:0] a;
    logic [11:0] c;
    spritePos = {32'd0, 32'd0, mk(10, 10, 1'b1), mk(0, 0, 1'b1)};
    rom_col[0] = 12'h0F0; rom_col[1] = 12'h00F;
    frame_end();
    pix(20, 20, a, c);
    frame_end();
    total++; if (collisionMask !== 4'b0011) $display("FAIL ares_pre_coll got=%b exp=0011", collisionMask); else passed++;
    x = 10'd20; y = 9'd20; active = 1'b1; hSync = 1'b1; vSync = 1'b1;
    step(); step(); step();
    total++; if (colorOut !== 12'h0F0) $display("FAIL ares_pre_color got=%h exp=0F0", colorOut); else passed++;
    #3 reset = 1'b1;
    #1;
    total++; if (colorOut !== 12'h000) $display("FAIL ares_color got=%h exp=000", colorOut); else passed++;
    total++; if (rom_if.spriteAddr !== 48'h0) $display("FAIL ares_addr got=%h exp=0", rom_if.spriteAddr); else passed++;
    total++; if (activeOut !== 1'b0) $display("FAIL ares_active got=%b exp=0", activeOut); else passed++;
    total++; if (hSyncOut !== 1'b0) $display("FAIL ares_hsync got=%b exp=0", hSyncOut); else passed++;
    total++; if (vSyncOut !== 1'b0) $display("FAIL ares_vsync got=%b exp=0", vSyncOut); else passed++;
    total++; if (collisionMask !== 4'h0) $display("FAIL ares_coll got=%b exp=0000", collisionMask); else passed++;
    total++; if (frameCount !== 16'h0) $display("FAIL ares_fc got=%0d exp=0", frameCount); else passed++;
    active = 1'b0; hSync = 1'b0; vSync = 1'b0;
    step();
    reset = 1'b0;
    exp_fc = 0;
    pix(20, 20, a, c);
    total++; if (c !== BG) $display("FAIL ares_shadow got=%h exp=%h", c, BG); else passed++;
    frame_end();
    total++; if (collisionMask !== 4'b0000) $display("FAIL ares_first_frame got=%b exp=0000", collisionMask); else passed++;
    total++; if (frameCount !== 16'd1) $display("FAIL ares_fc1 got=%0d exp=1", frameCount); else passed++;
  endtask

  task automatic test_frame_wrap();
    screenEnd = 1'b1; active = 1'b0;
    repeat (65534) step();
    total++; if (frameCount !== 16'hFFFF) $display("FAIL wrap_max got=%h exp=FFFF", frameCount); else passed++;
    step();
    total++; if (frameCount !== 16'h0000) $display("FAIL wrap_zero got=%h exp=0000", frameCount); else passed++;
    screenEnd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; screenEnd = 1'b0; active = 1'b0; hSync = 1'b0; vSync = 1'b0;
    x = '0; y = '0; spritePos = '0; bgColor = BG; corner_en = 1'b0;
    for (int i = 0; i < NS; i++) rom_col[i] = 12'h000;
    test_reset();
    test_single();
    test_back_to_back();
    test_priority();
    test_tear_free();
    test_collision();
    test_blanking_latency();
    test_boundaries();
    test_async_reset();
    test_frame_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
